// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : constants shared by uart_tx, uart_rx and uart_tx_arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : rotate-priority encoder, first set bit at or above ptr     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] cand [N_REQ];

    // cand[k] = (ptr + k) mod N_REQ; one spare bit keeps the sum exact
    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
        logic [PW:0] sum;
        assign sum     = {1'b0, ptr} + (PW+1)'(k);
        assign cand[k] = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : sum[PW-1:0];
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter : frame-locking round-robin share of one uart_tx     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]               req_last,
    output logic [N_REQ-1:0]               req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    output logic [$clog2(N_REQ)-1:0]       grant_id,
    output logic                           grant_active
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(LOCK_TIMEOUT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    logic [2:0]     state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic           last_w;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           accept;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] next_ptr;
    logic           timeout_hit;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // In HOLD only the lock owner may be accepted
    always_comb begin
        accept = 1'b0;
        sel    = grant_id;
        if (state == ST_IDLE) begin
            accept = pick_found;
            sel    = pick_idx;
        end else if (state == ST_HOLD) begin
            accept = req_valid[grant_id];
        end
    end

    assign next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    assign timeout_hit = (LOCK_TIMEOUT != 0) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            ptr          <= '0;
            cnt          <= '0;
            last_w       <= 1'b0;
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        tx_data        <= req_data[sel*UART_BYTE_W +: UART_BYTE_W];
                        req_ready[sel] <= 1'b1;
                        tx_start       <= 1'b1;
                        grant_id       <= sel;
                        grant_active   <= 1'b1;
                        last_w         <= req_last[sel];
                        cnt            <= '0;
                        state          <= ST_START;
                    end else if (state == ST_HOLD) begin
                        if (timeout_hit) begin
                            grant_active <= 1'b0;
                            ptr          <= next_ptr;
                            state        <= ST_IDLE;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_w) begin
                            grant_active <= 1'b0;
                            ptr          <= next_ptr;
                            state        <= ST_IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter : vector table, directed corners, random frames   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int LT = 20;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        grant_active;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0, fall_cyc = -1000;
    int dly = 0, left = 0, pend = 0;
    bit start_seen = 1'b0, rand_len = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // One clock: transmitter model updates after the edge, outputs sampled at negedge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (start_seen) begin
            pend = 1;
            dly  = rand_len ? int'($urandom_range(0, 1)) : 1;
        end
        if (pend != 0) begin
            if (dly == 0) begin
                tx_busy = 1'b1;
                left    = rand_len ? int'($urandom_range(1, 6)) : 4;
                pend    = 0;
            end else dly--;
        end else if (tx_busy) begin
            if (left == 0) begin
                tx_busy  = 1'b0;
                fall_cyc = cyc;
            end else left--;
        end
        @(negedge clk);
        start_seen = tx_start;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (n < max) begin
            step();
            n++;
            if (req_ready != 0) break;
        end
        if (req_ready == 0) begin
            n_chk++;
            $display("FAIL wait_ready: no req_ready within %0d cycles", max);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (grant_active && n < max) begin
            step();
            n++;
        end
        if (grant_active) begin
            n_chk++;
            $display("FAIL wait_idle: grant_active still 1 after %0d cycles", max);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  req_ready, 0);
        chk({tag, "_start"},  tx_start, 0);
        chk({tag, "_data"},   tx_data, 0);
        chk({tag, "_grant"},  grant_id, 0);
        chk({tag, "_active"}, grant_active, 0);
    endtask

    typedef struct {
        logic [3:0] vmask;
        logic [7:0] base;
        int         exp_w;
    } vec_t;

    vec_t tbl [12];

    logic [8:0] q [4][$];
    int         gap [4];

    task automatic drive_rand();
        for (int i = 0; i < N; i++) begin
            if (gap[i] > 0) gap[i]--;
            if (q[i].size() > 0 && gap[i] == 0) set_req(i, 1'b1, q[i][0][7:0], q[i][0][8]);
            else set_req(i, 1'b0, 8'h00, 1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, nrdy, w, owner, mptr, total, accepted;
        logic [3:0] vdec;
        logic [7:0] got [$];
        logic [7:0] lock_exp [4];
        logic       lst;

        // single requester, then 0/1/3 round robin, then assorted wraps
        tbl[0]  = '{4'b0100, 8'h3F, 2};
        tbl[1]  = '{4'b1011, 8'h10, 3};
        tbl[2]  = '{4'b1011, 8'h20, 0};
        tbl[3]  = '{4'b1011, 8'h30, 1};
        tbl[4]  = '{4'b1011, 8'h40, 3};
        tbl[5]  = '{4'b1011, 8'h50, 0};
        tbl[6]  = '{4'b0001, 8'h60, 0};
        tbl[7]  = '{4'b1000, 8'h70, 3};
        tbl[8]  = '{4'b0110, 8'h80, 1};
        tbl[9]  = '{4'b0110, 8'h90, 2};
        tbl[10] = '{4'b0001, 8'hA0, 0};
        tbl[11] = '{4'b1111, 8'hB0, 1};

        step();
        step();
        chk_reset_outputs("reset");
        rstn = 1'b1;
        step();

        for (int e = 0; e < 12; e++) begin
            for (int i = 0; i < N; i++)
                if (tbl[e].vmask[i]) set_req(i, 1'b1, tbl[e].base + 8'(i), 1'b1);
            wait_ready(10, n);
            chk("tbl_latency", n, 1);
            chk("tbl_ready",   req_ready, 32'(1) << tbl[e].exp_w);
            chk("tbl_data",    tx_data, tbl[e].base + 8'(tbl[e].exp_w));
            chk("tbl_grant",   grant_id, tbl[e].exp_w);
            chk("tbl_start",   tx_start, 1);
            chk("tbl_active",  grant_active, 1);
            req_valid = '0;
            step();
            chk("tbl_pulse", {tx_start, req_ready}, 0);
            wait_idle(50);
            chk("tbl_data_hold", tx_data, tbl[e].base + 8'(tbl[e].exp_w));
        end

        // Frame lock: req 1 pauses inside its frame while req 0 waits
        lock_exp = '{8'h10, 8'h11, 8'h12, 8'hEE};
        set_req(1, 1'b1, 8'h10, 1'b0);
        n = 0;
        nrdy = 0;
        for (int c = 0; c < 300 && got.size() < 4; c++) begin
            step();
            if (tx_start) got.push_back(tx_data);
            if (req_ready[1]) begin
                n++;
                req_valid[1] = 1'b0;
                nrdy = 12;
                if (n == 1) set_req(0, 1'b1, 8'hEE, 1'b1);
            end else if (nrdy > 0) begin
                nrdy--;
                if (nrdy == 0 && n < 3) set_req(1, 1'b1, 8'h10 + 8'(n), n == 2);
            end
            if (req_ready[0]) req_valid[0] = 1'b0;
        end
        chk("lock_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("lock_order", got[i], lock_exp[i]);
        chk("lock_then_req0", grant_id, 0);
        req_valid = '0;
        wait_idle(50);

        // Timeout: req 3 goes silent mid-frame, req 0 pending
        set_req(3, 1'b1, 8'h55, 1'b0);
        wait_ready(10, n);
        chk("to_grant", grant_id, 3);
        req_valid[3] = 1'b0;
        set_req(0, 1'b1, 8'hA5, 1'b1);
        nrdy = 0;
        for (int c = 0; c < 100 && grant_active; c++) begin
            step();
            if (req_ready != 0) nrdy++;
        end
        chk("to_no_early_grant", nrdy, 0);
        chk("to_release_cycle", cyc - fall_cyc, LT + 2);
        wait_ready(3, n);
        chk("to_next_latency", n, 1);
        chk("to_next_ready", req_ready, 4'b0001);
        chk("to_next_data", tx_data, 8'hA5);
        req_valid = '0;
        wait_idle(50);
        set_req(0, 1'b1, 8'h01, 1'b1);
        set_req(1, 1'b1, 8'h02, 1'b1);
        wait_ready(3, n);
        chk("to_ptr_after", grant_id, 1);
        req_valid = '0;
        wait_idle(50);

        // Timeout tie: owner byte arrives on the cycle the timeout would fire
        set_req(2, 1'b1, 8'h66, 1'b0);
        wait_ready(10, n);
        req_valid[2] = 1'b0;
        fall_cyc = -1000;
        for (int c = 0; c < 100 && cyc != fall_cyc + LT + 1; c++) step();
        chk("tie_reached", cyc - fall_cyc, LT + 1);
        set_req(2, 1'b1, 8'h67, 1'b0);
        step();
        chk("tie_ready",  req_ready, 4'b0100);
        chk("tie_data",   tx_data, 8'h67);
        chk("tie_active", grant_active, 1);
        req_valid[2] = 1'b0;
        fall_cyc = -1000;
        for (int c = 0; c < 100 && grant_active; c++) step();
        chk("tie_counter_restart", cyc - fall_cyc, LT + 2);

        // Reset during WAIT_DONE
        set_req(1, 1'b1, 8'h31, 1'b0);
        wait_ready(10, n);
        set_req(1, 1'b1, 8'h32, 1'b1);
        for (int c = 0; c < 20 && !tx_busy; c++) step();
        step();
        rstn = 1'b0;
        req_valid = '0;
        step();
        chk_reset_outputs("midrst");
        step();
        rstn = 1'b1;
        nrdy = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (req_ready != 0 || tx_start) nrdy++;
        end
        chk("midrst_no_accept", nrdy, 0);
        chk("midrst_no_lock", grant_active, 0);

        // Random frames against a transaction-level round-robin model
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) step();
        rand_len = 1'b1;
        total = 0;
        accepted = 0;
        for (int i = 0; i < N; i++) begin
            gap[i] = int'($urandom_range(0, 3));
            for (int f = int'($urandom_range(3, 6)); f > 0; f--) begin
                n = int'($urandom_range(1, 3));
                for (int b = 0; b < n; b++) begin
                    q[i].push_back({b == n - 1, 8'($urandom)});
                    total++;
                end
            end
        end
        owner = -1;
        mptr = 0;
        drive_rand();
        for (int c = 0; c < 20000 && accepted < total; c++) begin
            vdec = req_valid;
            step();
            if (tx_start || req_ready != 0) begin
                chk("rand_start_with_ready", tx_start, req_ready != 0);
                w = owner;
                if (w < 0)
                    for (int k = 0; k < N; k++)
                        if (w < 0 && vdec[(mptr + k) % N]) w = (mptr + k) % N;
                if (w < 0 || q[w].size() == 0) begin
                    n_chk++;
                    $display("FAIL rand_accept: req_ready=0x%0h, expected none", req_ready);
                end else begin
                    chk("rand_ready", req_ready, 32'(1) << w);
                    chk("rand_was_valid", vdec[w], 1);
                    chk("rand_data", tx_data, q[w][0][7:0]);
                    chk("rand_grant", grant_id, w);
                    chk("rand_line_free", tx_busy, 0);
                    lst = q[w][0][8];
                    void'(q[w].pop_front());
                    accepted++;
                    if (lst) begin
                        owner = -1;
                        mptr = (w + 1) % N;
                        gap[w] = int'($urandom_range(0, 3));
                    end else owner = w;
                end
            end
            drive_rand();
        end
        chk("rand_all_sent", accepted, total);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
